// File: rtl/montgomery_pkg.sv
// rtl/montgomery_pkg.sv - shared operand width, state encoding and counter width for the Montgomery multiplier
package montgomery_pkg;

    localparam int N = 1024;

    // Counter width for an n-iteration loop; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        REDUCE = 2'd2
    } state_t;

endpackage

// File: rtl/mont_add_sub.sv
// rtl/mont_add_sub.sv - shared adder/subtractor for the iteration sum and final compare-subtract
module mont_add_sub #(
    parameter int W = 1026
) (
    input  logic         sub,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] res,
    output logic         borrow
);

    logic [W:0] diff;

    // sub=0: three-operand sum x+y+z; sub=1: x-y with borrow flagging x<y
    always_comb begin
        diff   = {1'b0, x} - {1'b0, y};
        res    = x + y + z;
        borrow = 1'b0;
        if (sub) begin
            res    = diff[W-1:0];
            borrow = diff[W];
        end
    end

endmodule

// File: rtl/montgomery.sv
// rtl/montgomery.sv - radix-2 bit-serial Montgomery multiplier, result = A*B*2^-N mod M
module montgomery
    import montgomery_pkg::*;
#(
    parameter int N = montgomery_pkg::N
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int CW = cnt_width(N);

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    m_q;
    logic [N+1:0]    c_q;
    logic [CW-1:0]   cnt_q;

    logic            a_bit;
    logic            q_bit;
    logic            as_sub;
    logic [N+1:0]    as_y;
    logic [N+1:0]    as_z;
    logic [N+1:0]    as_res;
    logic            as_borrow;
    logic            last_iter;

    assign a_bit     = a_q[0];
    // q is the parity of C + a_i*B, known without waiting for the full add
    assign q_bit     = c_q[0] ^ (a_bit & b_q[0]);
    assign last_iter = (cnt_q == CW'(N - 1));

    // Operand steering: iteration sum in MULT, C - M in REDUCE
    always_comb begin
        as_sub = 1'b0;
        as_y   = '0;
        as_z   = '0;
        if (state_q == REDUCE) begin
            as_sub = 1'b1;
            as_y   = {2'b00, m_q};
        end else begin
            if (a_bit) as_y = {2'b00, b_q};
            if (q_bit) as_z = {2'b00, m_q};
        end
    end

    mont_add_sub #(
        .W (N + 2)
    ) u_add_sub (
        .sub    (as_sub),
        .x      (c_q),
        .y      (as_y),
        .z      (as_z),
        .res    (as_res),
        .borrow (as_borrow)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: start only matters in IDLE, MULT runs N iterations
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MULT;
            MULT:    if (last_iter) state_d = REDUCE;
            REDUCE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, iterate C, then load the reduced result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        m_q   <= in_m;
                        c_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                MULT: begin
                    c_q   <= {1'b0, as_res[N+1:1]};
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                REDUCE: begin
                    result <= as_borrow ? c_q[N-1:0] : as_res[N-1:0];
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery.sv
// tb/tb_montgomery.sv - scoreboard testbench for the Montgomery multiplier
module tb_montgomery;

    localparam int N = 1024;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic [N-1:0] result;
    logic         done;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic         prev_done = 1'b0;
    logic [N-1:0] exp_q[$];
    int           cyc_q[$];
    logic [N-1:0] mon_exp;
    int           mon_t0;

    montgomery #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ..%h want ..%h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Reference: reduce A*B mod M, then halve modulo M N times (x/2 mod M).
    function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [N-1:0] m);
        logic [2*N-1:0] x;
        x = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % {{N{1'b0}}, m};
        for (int i = 0; i < N; i++) begin
            if (x[0]) x = x + {{N{1'b0}}, m};
            x = x >> 1;
        end
        return x[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard consumer: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            check_eq("done_width", {{(N-1){1'b0}}, prev_done}, '0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", {{(N-1){1'b0}}, done}, '0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_t0  = cyc_q.pop_front();
                check_eq("result", result, mon_exp);
                check_eq("latency", N'(cyc - mon_t0), N'(N + 1));
            end
        end
        prev_done = done;
    end

    // Called at a negedge; start is accepted at the following rising edge
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                         input bit track, input logic [N-1:0] exp);
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        if (track) begin
            exp_q.push_back(exp);
            cyc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        start = 1'b0;
        in_a  = rand_wide();
        in_b  = rand_wide();
        in_m  = rand_wide();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check_eq("timeout", N'(exp_q.size()), '0);
            exp_q.delete();
            cyc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [N-1:0] ones;
    logic [N-1:0] one;
    logic [N-1:0] a, b, m, a2, b2, m2;

    initial begin
        ones   = '1;
        one    = N'(1);
        resetn = 1'b0;
        start  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_m   = '0;
        #1;
        check_eq("reset_result", result, '0);
        check_eq("reset_done", {{(N-1){1'b0}}, done}, '0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // M = 2^N-1, A=B=1 -> 1; start on the very first edge after reset
        issue(one, one, ones, 1'b1, one);
        wait_idle();

        // A=1, B=M-1 -> M-1
        issue(one, ones - 1'b1, ones, 1'b1, {{(N-1){1'b1}}, 1'b0});
        wait_idle();

        // A=0 -> 0
        m = rand_wide() | {1'b1, {(N-2){1'b0}}, 1'b1};
        issue('0, rand_wide() % m, m, 1'b1, '0);
        wait_idle();

        // Random operands checked against the reference model
        for (int t = 0; t < 3; t++) begin
            m = rand_wide() | {1'b1, {(N-2){1'b0}}, 1'b1};
            a = rand_wide() % m;
            b = rand_wide() % m;
            issue(a, b, m, 1'b1, mont_ref(a, b, m));
            wait_idle();
        end

        // start re-pulsed mid-MULT with other operands must be ignored
        m  = rand_wide() | {1'b1, {(N-2){1'b0}}, 1'b1};
        a  = rand_wide() % m;
        b  = rand_wide() % m;
        issue(a, b, m, 1'b1, mont_ref(a, b, m));
        repeat (200) @(negedge clk);
        in_a  = rand_wide() % m;
        in_b  = rand_wide() % m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // resetn pulsed mid-MULT: outputs clear at once, no done afterwards
        m = rand_wide() | {1'b1, {(N-2){1'b0}}, 1'b1};
        issue(rand_wide() % m, rand_wide() % m, m, 1'b0, '0);
        repeat (300) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("midreset_result", result, '0);
        check_eq("midreset_done", {{(N-1){1'b0}}, done}, '0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (N + 20) @(negedge clk);

        // Back-to-back: second start issued in the first IDLE cycle
        m  = rand_wide() | {1'b1, {(N-2){1'b0}}, 1'b1};
        a  = rand_wide() % m;
        b  = rand_wide() % m;
        m2 = rand_wide() | {1'b1, {(N-2){1'b0}}, 1'b1};
        a2 = rand_wide() % m2;
        b2 = rand_wide() % m2;
        issue(a, b, m, 1'b1, mont_ref(a, b, m));
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        issue(a2, b2, m2, 1'b1, mont_ref(a2, b2, m2));
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
